// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: reset address, fetch FSM states,
// opcode field position and PC alignment helper.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc_plus4, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, br_taken, br_target, jump, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc_plus4, instr_valid,
    output imem_ack, imem_rdata, instr_ready, br_taken, br_target, jump, jump_target
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter register; every value it takes, including the reset value,
// is word aligned.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] pc_q
);

  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = pc_align(load_val);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= pc_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at the PC, holds it for decode until
// retired, then redirects the PC (jump > branch > sequential).
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_seq;
  logic [31:0]  pc_next;
  logic         pc_load;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_next),
    .pc_q     (pc_q)
  );

  assign pc_seq = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    pc_load    = 1'b0;
    pc_next    = pc_seq;
    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          pc_plus4_d = pc_seq;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirect inputs only matter in the cycle the instruction retires.
        if (bus.instr_ready) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
          if (bus.jump) begin
            pc_next = bus.jump_target;
          end else if (bus.br_taken) begin
            pc_next = bus.br_target;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // Request is masked while reset is held so memory sees it only after release.
  assign bus.imem_req    = (state_q == ST_FETCH) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign bus.pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses,
// held instructions and state snapshots; a negedge monitor pops and compares.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  opc;
    logic [31:0] pcp4;
  } instr_exp_t;

  typedef struct {
    string       name;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] addr;
  } snap_t;

  logic clk;
  logic rst;
  logic stim_done;
  int   checks;
  int   failures;

  logic [31:0] exp_addr_q[$];
  instr_exp_t  exp_instr_q[$];
  snap_t       snap_q[$];

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input string name, input logic req, input logic valid,
                           input logic [31:0] instr, input logic [31:0] addr);
    snap_t s;
    s.name  = name;
    s.req   = req;
    s.valid = valid;
    s.instr = instr;
    s.addr  = addr;
    snap_q.push_back(s);
  endtask

  // Memory model: waits for a request, acks after 'delay' cycles.
  task automatic serve(input int delay, input logic [31:0] data,
                       input logic [5:0] opc, input logic [31:0] pcp4);
    instr_exp_t e;
    int n;
    e.instr = data;
    e.opc   = opc;
    e.pcp4  = pcp4;
    exp_instr_q.push_back(e);
    n = 0;
    bus.jump        = 1'b1;
    bus.jump_target = 32'hAAAA_AAA8;
    bus.br_taken    = 1'b1;
    bus.br_target   = 32'h5555_5554;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.imem_req) push_snap("req_timeout", 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (delay) step();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hBAD0_BAD0;
    bus.jump       = 1'b0;
    bus.br_taken   = 1'b0;
  endtask

  task automatic retire(input logic j, input logic [31:0] jt, input logic b,
                        input logic [31:0] bt, input logic [31:0] exp_next);
    exp_addr_q.push_back(exp_next);
    bus.jump        = j;
    bus.jump_target = jt;
    bus.br_taken    = b;
    bus.br_target   = bt;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.br_taken    = 1'b0;
  endtask

  // Stimulus
  initial begin
    stim_done       = 1'b0;
    rst             = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = 32'h0;
    bus.jump        = 1'b0;
    bus.jump_target = 32'h0;
    #2 rst = 1'b1;
    step();
    step();
    push_snap("reset_state", 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // First fetch from RESET_PC, 1-cycle ack delay
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    serve(1, 32'h2008_0005, 6'b001000, 32'h4);

    // Jump beats branch
    retire(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 32'h40);
    serve(0, 32'h0800_0010, 6'b000010, 32'h44);

    // Branch with misaligned target
    retire(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0000_0013, 32'h10);
    serve(2, 32'h1000_FFFF, 6'b000100, 32'h14);

    // Stall in HOLD with toggling branch/ack; nothing may change
    for (int i = 0; i < 5; i++) begin
      bus.br_taken   = i[0];
      bus.br_target  = 32'h0000_0100;
      bus.imem_ack   = i[0];
      bus.imem_rdata = 32'hFFFF_0000;
      push_snap("hold_stall", 1'b0, 1'b1, 32'h1000_FFFF, 32'h10);
      step();
    end
    bus.imem_ack = 1'b0;
    bus.br_taken = 1'b0;
    retire(1'b0, 32'h0, 1'b0, 32'h0, 32'h14);
    serve(0, 32'h8C01_0004, 6'b100011, 32'h18);

    // Wrap-around of PC+4
    retire(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'hFFFF_FFFC);
    serve(0, 32'h0000_0020, 6'b000000, 32'h0);
    retire(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    serve(0, 32'h2108_0001, 6'b001000, 32'h4);

    // Reset while a request is outstanding
    retire(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    step();
    step();
    #1 rst = 1'b1;
    push_snap("rst_midfetch", 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    push_snap("rst_held", 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    serve(1, 32'h3C01_1234, 6'b001111, 32'h4);
    retire(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    step();
    step();
    stim_done = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic        prev_req;
    logic        prev_valid;
    logic [31:0] cur_addr;
    instr_exp_t  cur_i;
    snap_t       s;
    checks     = 0;
    failures   = 0;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    cur_addr   = 32'h0;
    cur_i.instr = 32'h0;
    cur_i.opc   = 6'h0;
    cur_i.pcp4  = 32'h0;
    while (!stim_done) begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.name, "_req"},   {31'h0, bus.imem_req},    {31'h0, s.req});
        chk({s.name, "_valid"}, {31'h0, bus.instr_valid}, {31'h0, s.valid});
        chk({s.name, "_instr"}, bus.instr,                s.instr);
        chk({s.name, "_addr"},  bus.imem_addr,            s.addr);
      end
      if (bus.imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_addr);
        end else begin
          cur_addr = exp_addr_q.pop_front();
          chk("req_addr", bus.imem_addr, cur_addr);
        end
      end else if (bus.imem_req) begin
        chk("req_addr_stable", bus.imem_addr, cur_addr);
      end
      if (bus.instr_valid && !prev_valid) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got instr %h expected none", bus.instr);
        end else begin
          cur_i = exp_instr_q.pop_front();
          chk("instr", bus.instr, cur_i.instr);
          chk("opcode", {26'h0, bus.opcode}, {26'h0, cur_i.opc});
          chk("pc_plus4", bus.pc_plus4, cur_i.pcp4);
        end
      end else if (bus.instr_valid) begin
        chk("instr_stable", bus.instr, cur_i.instr);
      end
      prev_req   = bus.imem_req;
      prev_valid = bus.instr_valid;
    end
    chk("addr_queue_empty",  exp_addr_q.size(),  32'd0);
    chk("instr_queue_empty", exp_instr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
